alu: RTL and testbench
======================

Name:
alu

Overview:
- Parameterised N-bit arithmetic/logic unit with a start/finished handshake.
- Single-cycle ops (add, sub, logic, shifts, rotates) complete in 1 cycle.
- Multiply and divide are iterative and take N cycles.
- Two result words: Y is the primary result; X is the extension (carry/borrow, product high half, remainder).

Parameters:
- N, 4, operand/result width in bits (N >= 2).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- finished  output  1  one-cycle completion pulse (registered)
- opcode  input  5  operation select; latched with start
- A  input  N  operand A; latched with start
- B  input  N  operand B; latched with start
- Y  output  N  primary result (registered)
- X  output  N  extension result (registered)

Behaviour:
- Reset (sync, active-high, highest priority):
  - state=IDLE; Y=0, X=0, finished=0.
  - Aborts any in-flight op; no finished pulse follows.
- States are IDLE, BUSY and DONE.
  - IDLE: start=1 at edge k latches opcode/A/B. Single-cycle op: Y/X written at edge k, go to DONE. MUL/DIV: go to BUSY with step counter=N.
  - BUSY: one iteration per edge. After N iterations (edge k+N), Y/X written and go to DONE.
  - DONE: finished=1 for exactly this cycle; next edge returns to IDLE.
- Latency:
  - finished is visible after edge k for single-cycle ops.
  - finished is visible after edge k+N for MUL/DIV.
  - Minimum start-to-start spacing is 2 cycles (single-cycle) or N+2 cycles (iterative).
- start is ignored in BUSY and DONE.
- A, B and opcode may change after the latch edge without affecting the op.
- Y/X hold the previous result until the new op completes. They never show partial values during BUSY.
- Opcodes (unsigned unless noted; X=0 unless stated):
  - 00000 PASS: Y=A
  - 00001 ADD: Y=(A+B) mod 2^N; X[0]=carry out
  - 00010 SUB: Y=(A-B) mod 2^N; X[0]=borrow (A<B)
  - 00011 AND: Y=A&B
  - 00100 OR: Y=A|B
  - 00101 XOR: Y=A^B
  - 00110 NOT: Y=~A
  - 00111 SHL: Y=A<<B; B>=N gives Y=0
  - 01000 SHR: logical right; B>=N gives Y=0
  - 01001 SAR: arithmetic right; B>=N gives all bits = A[N-1]
  - 01010 ROL: rotate left by B mod N
  - 01011 ROR: rotate right by B mod N
  - 01100 INC: Y=A+1 mod 2^N; X[0]=carry
  - 01101 DEC: Y=A-1 mod 2^N; X[0]=borrow (A==0)
  - 01110 NEG: Y=(-A) mod 2^N
  - 10000 MUL: {X,Y}=A*B, 2N-bit unsigned. Shift-add, one bit of B per cycle, N cycles.
  - 10001 DIV: Y=A/B, X=A%B. Restoring division, one quotient bit per cycle, N cycles. B==0 still takes N cycles and gives Y=all ones, X=A.
  - All other opcodes: Y=0, X=0, single-cycle, finished still pulses.
- Unused upper bits of X are 0 for carry/borrow ops.

Test Plan:
- N=4, ADD A=9 B=8, start 1 cycle -> after edge k: Y=1, X=1, finished=1 for exactly one cycle; SUB A=3 B=5 -> Y=14, X=1.
- MUL A=13 B=11 -> finished high after edge k+4 only, X=8, Y=15 (143). Y/X keep their prior values during BUSY.
- DIV A=13 B=4 -> Y=3, X=1 after 4 cycles; DIV A=13 B=0 -> Y=15, X=13 after 4 cycles.
- Shifts/rotates: SAR A=1000b B=2 -> Y=1110b; SHL A=0011b B=5 -> Y=0; ROL A=1001b B=5 -> Y=0011b.
- Start pulsed during BUSY and DONE -> ignored, result unchanged, no extra finished pulse. Undefined opcode 11111 -> Y=0, X=0, finished pulses.
- Reset asserted mid-MUL (edge k+2) -> Y=0, X=0, finished never pulses, state IDLE. A new start on the next cycle completes normally.

Source files
------------

// File: rtl/alu_if.sv
// Request/response bundle for the ALU: operands and opcode in, results and completion pulse out.
interface alu_if #(parameter int N = 4);
    logic         start;
    logic         finished;
    logic [4:0]   opcode;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Y;
    logic [N-1:0] X;

    modport master (output start, opcode, A, B, input finished, Y, X);
    modport slave  (input start, opcode, A, B, output finished, Y, X);
endinterface

// File: rtl/alu.sv
// N-bit ALU: single-cycle ops finish at the latch edge; MUL/DIV iterate N cycles in a shared hi/lo register pair.
// Y/X only change when an op completes; start is honoured only in IDLE.
module alu #(
    parameter int N = 4
) (
    input logic   clock,
    input logic   reset,
    alu_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [4:0] OP_PASS = 5'b00000, OP_ADD = 5'b00001, OP_SUB = 5'b00010,
                           OP_AND  = 5'b00011, OP_OR  = 5'b00100, OP_XOR = 5'b00101,
                           OP_NOT  = 5'b00110, OP_SHL = 5'b00111, OP_SHR = 5'b01000,
                           OP_SAR  = 5'b01001, OP_ROL = 5'b01010, OP_ROR = 5'b01011,
                           OP_INC  = 5'b01100, OP_DEC = 5'b01101, OP_NEG = 5'b01110,
                           OP_MUL  = 5'b10000, OP_DIV = 5'b10001;
    localparam int          CW = $clog2(N + 1);
    localparam logic [N-1:0] NW = N[N-1:0];

    state_t        state_q, state_d;
    logic [N-1:0]  y_q, y_d, x_q, x_d;
    logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, opr_q, opr_d;
    logic          div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          iter_op;
    logic [N-1:0]  sy, sx, rot;
    logic [N:0]    sum;
    logic [2*N-1:0] rotl, rotr;
    logic [N:0]    mul_sum, div_sh, div_tr;
    logic          div_ge;
    logic [N-1:0]  hi_n, lo_n;

    assign iter_op = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);

    // Single-cycle results come straight from the ports: they are written on the latch edge.
    always_comb begin
        sy   = '0;
        sx   = '0;
        sum  = '0;
        rot  = bus.B % NW;
        rotl = {bus.A, bus.A} << rot;
        rotr = {bus.A, bus.A} >> rot;
        case (bus.opcode)
            OP_PASS: sy = bus.A;
            OP_ADD: begin
                sum = {1'b0, bus.A} + {1'b0, bus.B};
                sy  = sum[N-1:0];
                sx  = {{(N-1){1'b0}}, sum[N]};
            end
            OP_SUB: begin
                sum = {1'b0, bus.A} - {1'b0, bus.B};
                sy  = sum[N-1:0];
                sx  = {{(N-1){1'b0}}, sum[N]};
            end
            OP_AND:  sy = bus.A & bus.B;
            OP_OR:   sy = bus.A | bus.B;
            OP_XOR:  sy = bus.A ^ bus.B;
            OP_NOT:  sy = ~bus.A;
            OP_SHL:  sy = bus.A << bus.B;
            OP_SHR:  sy = bus.A >> bus.B;
            OP_SAR:  sy = $signed(bus.A) >>> bus.B;
            OP_ROL:  sy = rotl[2*N-1:N];
            OP_ROR:  sy = rotr[N-1:0];
            OP_INC: begin
                sum = {1'b0, bus.A} + {{N{1'b0}}, 1'b1};
                sy  = sum[N-1:0];
                sx  = {{(N-1){1'b0}}, sum[N]};
            end
            OP_DEC: begin
                sum = {1'b0, bus.A} - {{N{1'b0}}, 1'b1};
                sy  = sum[N-1:0];
                sx  = {{(N-1){1'b0}}, sum[N]};
            end
            OP_NEG:  sy = '0 - bus.A;
            default: ;
        endcase
    end

    // One iteration: MUL shifts {hi,lo} right after adding the multiplicand; DIV shifts left and trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : '0);
        div_sh  = {hi_q, lo_q[N-1]};
        div_tr  = div_sh - {1'b0, opr_q};
        div_ge  = div_sh >= {1'b0, opr_q};
        if (div_q) begin
            hi_n = div_ge ? div_tr[N-1:0] : div_sh[N-1:0];
            lo_n = {lo_q[N-2:0], div_ge};
        end else begin
            hi_n = mul_sum[N:1];
            lo_n = {mul_sum[0], lo_q[N-1:1]};
        end
    end

    always_comb begin
        y_d   = y_q;
        x_d   = x_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        opr_d = opr_q;
        div_d = div_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (iter_op) begin
                        div_d = (bus.opcode == OP_DIV);
                        cnt_d = CW'(N);
                        hi_d  = '0;
                        lo_d  = (bus.opcode == OP_DIV) ? bus.A : bus.B;
                        opr_d = (bus.opcode == OP_DIV) ? bus.B : bus.A;
                    end else begin
                        y_d = sy;
                        x_d = sx;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    y_d = lo_n;
                    x_d = hi_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            y_q   <= '0;
            x_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            opr_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            x_q   <= x_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opr_q <= opr_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = iter_op ? S_BUSY : S_DONE;
            S_BUSY:  if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.finished = (state_q == S_DONE);
        bus.Y        = y_q;
        bus.X        = x_q;
    end
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu at N=4; expected values are hand-computed constants.
module tb_alu;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [N-1:0] prev_y, prev_x;

    alu_if #(.N(N)) bus ();
    alu #(.N(N)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
        tick();
        bus.start  = 1'b0;
        bus.opcode = 5'(($urandom));
        bus.A      = N'($urandom);
        bus.B      = N'($urandom);
    endtask

    task automatic single(input string tag, input logic [4:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] ey, input logic [N-1:0] ex);
        issue(op, a, b);
        check({tag, "_y"}, 8'(bus.Y), 8'(ey));
        check({tag, "_x"}, 8'(bus.X), 8'(ex));
        check({tag, "_fin"}, 8'(bus.finished), 8'd1);
        tick();
        check({tag, "_fin_drop"}, 8'(bus.finished), 8'd0);
        prev_y = ey;
        prev_x = ex;
    endtask

    task automatic iter(input string tag, input logic [4:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] ey, input logic [N-1:0] ex);
        issue(op, a, b);
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy_fin"}, 8'(bus.finished), 8'd0);
            check({tag, "_busy_y"}, 8'(bus.Y), 8'(prev_y));
            check({tag, "_busy_x"}, 8'(bus.X), 8'(prev_x));
            if (i < N - 1) tick();
        end
        tick();
        check({tag, "_y"}, 8'(bus.Y), 8'(ey));
        check({tag, "_x"}, 8'(bus.X), 8'(ex));
        check({tag, "_fin"}, 8'(bus.finished), 8'd1);
        prev_y = ey;
        prev_x = ex;
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.A      = '0;
        bus.B      = '0;
        tick();
        tick();
        check("rst_y", 8'(bus.Y), 8'd0);
        check("rst_x", 8'(bus.X), 8'd0);
        check("rst_fin", 8'(bus.finished), 8'd0);
        rst = 1'b0;
        tick();

        single("add_9_8",  5'b00001, 4'd9,  4'd8, 4'd1,  4'd1);
        single("pass",     5'b00000, 4'd5,  4'd3, 4'd5,  4'd0);
        single("and",      5'b00011, 4'd12, 4'd10, 4'd8, 4'd0);
        single("or",       5'b00100, 4'd12, 4'd10, 4'd14, 4'd0);
        single("xor",      5'b00101, 4'd12, 4'd10, 4'd6, 4'd0);
        single("not",      5'b00110, 4'd5,  4'd0, 4'd10, 4'd0);
        single("shl_3_5",  5'b00111, 4'd3,  4'd5, 4'd0,  4'd0);
        single("shl_3_2",  5'b00111, 4'd3,  4'd2, 4'd12, 4'd0);
        single("shr_12_1", 5'b01000, 4'd12, 4'd1, 4'd6,  4'd0);
        single("shr_12_4", 5'b01000, 4'd12, 4'd4, 4'd0,  4'd0);
        single("sar_8_2",  5'b01001, 4'd8,  4'd2, 4'd14, 4'd0);
        single("sar_8_7",  5'b01001, 4'd8,  4'd7, 4'd15, 4'd0);
        single("sar_7_9",  5'b01001, 4'd7,  4'd9, 4'd0,  4'd0);
        single("rol_9_5",  5'b01010, 4'd9,  4'd5, 4'd3,  4'd0);
        single("rol_9_4",  5'b01010, 4'd9,  4'd4, 4'd9,  4'd0);
        single("ror_9_1",  5'b01011, 4'd9,  4'd1, 4'd12, 4'd0);
        single("inc_15",   5'b01100, 4'd15, 4'd0, 4'd0,  4'd1);
        single("dec_0",    5'b01101, 4'd0,  4'd0, 4'd15, 4'd1);
        single("neg_3",    5'b01110, 4'd3,  4'd0, 4'd13, 4'd0);
        single("undef_31", 5'b11111, 4'd7,  4'd7, 4'd0,  4'd0);
        single("add_7_8",  5'b00001, 4'd7,  4'd8, 4'd15, 4'd0);
        single("sub_3_5",  5'b00010, 4'd3,  4'd5, 4'd14, 4'd1);

        iter("mul_13_11", 5'b10000, 4'd13, 4'd11, 4'd15, 4'd8);
        tick();
        iter("div_13_4",  5'b10001, 4'd13, 4'd4,  4'd3,  4'd1);
        tick();
        iter("div_13_0",  5'b10001, 4'd13, 4'd0,  4'd15, 4'd13);
        tick();
        iter("div_14_3",  5'b10001, 4'd14, 4'd3,  4'd4,  4'd2);
        tick();
        iter("mul_15_15", 5'b10000, 4'd15, 4'd15, 4'd1,  4'd14);
        tick();

        // Start pulses while BUSY and while DONE must be dropped.
        issue(5'b10000, 4'd2, 4'd3);
        bus.start = 1'b1; bus.opcode = 5'b00001; bus.A = 4'd1; bus.B = 4'd1;
        tick();
        bus.start = 1'b0;
        check("busy_start_fin", 8'(bus.finished), 8'd0);
        tick();
        tick();
        tick();
        check("busy_start_y", 8'(bus.Y), 8'd6);
        check("busy_start_x", 8'(bus.X), 8'd0);
        check("busy_start_done", 8'(bus.finished), 8'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_fin", 8'(bus.finished), 8'd0);
        check("done_start_y", 8'(bus.Y), 8'd6);
        tick();
        check("done_start_idle_fin", 8'(bus.finished), 8'd0);
        check("done_start_idle_y", 8'(bus.Y), 8'd6);

        // Reset lands on edge k+2 of a multiply.
        issue(5'b10000, 4'd13, 4'd11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_y", 8'(bus.Y), 8'd0);
        check("abort_x", 8'(bus.X), 8'd0);
        check("abort_fin", 8'(bus.finished), 8'd0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check("abort_no_fin", 8'(bus.finished), 8'd0);
            check("abort_hold_y", 8'(bus.Y), 8'd0);
        end
        prev_y = '0;
        prev_x = '0;
        single("post_abort_add", 5'b00001, 4'd2, 4'd3, 4'd5, 4'd0);
        iter("post_abort_mul", 5'b10000, 4'd3, 4'd5, 4'd15, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
